// File: rtl/a2s_pkg.sv
// a2s_pkg: mode encodings and min-int detect shared by the a2s_pipe datapath
package a2s_pkg;
  localparam logic [1:0] MODE_NEG   = 2'b00;
  localparam logic [1:0] MODE_ABS   = 2'b01;
  localparam logic [1:0] MODE_SM2TC = 2'b10;
  localparam logic [1:0] MODE_TC2SM = 2'b11;
  localparam int MAX_W = 256;
  // True when the low w bits of a are {1'b1, {w-1{1'b0}}}
  function automatic logic is_min(input logic [MAX_W-1:0] a, input int unsigned w);
    return (a & ((MAX_W'(1) << w) - MAX_W'(1))) == (MAX_W'(1) << (w - 1));
  endfunction
endpackage

// File: rtl/a2s_pipe_stage.sv
// a2s_pipe_stage: valid/ready register slice, loads when empty or when the next slice loads
module a2s_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  input  logic         next_load_i,
  output logic         load_o,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic         valid_q;
  logic [W-1:0] data_q;
  assign load_o  = !valid_q || next_load_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_o) begin
      valid_q <= valid_i;
      if (valid_i) data_q <= data_i;
    end
  end
endmodule

// File: rtl/a2s_pipe.sv
// a2s_pipe: pipelined negate / abs / sign-magnitude <-> two's-complement converter
module a2s_pipe
  import a2s_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int FW = WIDTH + 4;
  localparam int OW = WIDTH + 2;
  logic [WIDTH-1:0] s_inv, f_inv, f_sum, f_y;
  logic             s_inc, s_min, f_inc, f_min, f_ovf, f_zero, load1;
  logic [1:0]       f_mode;
  // Front half: conditional inversion; the +1 is carried as s_inc into the back half
  always_comb begin
    s_min = is_min(MAX_W'(in_a), WIDTH);
    s_inc = (in_mode == MODE_NEG) || in_a[WIDTH-1];
    s_inv = !s_inc ? in_a :
            (in_mode == MODE_SM2TC) ? ~{1'b0, in_a[WIDTH-2:0]} : ~in_a;
  end
  always_comb begin
    f_sum  = f_inv + WIDTH'(f_inc);
    f_ovf  = f_min && (f_mode != MODE_SM2TC);
    f_y    = (f_mode == MODE_TC2SM && f_min) ? '1 :
             (f_mode == MODE_TC2SM && f_inc) ? {1'b1, f_sum[WIDTH-2:0]} : f_sum;
    f_zero = (f_y == '0);
  end
  assign in_ready = load1 && !rst;
  if (LATENCY == 1) begin : g_lat1
    assign {f_inv, f_inc, f_mode, f_min} = {s_inv, s_inc, in_mode, s_min};
    a2s_pipe_stage #(.W(OW)) u_s2 (
      .clk(clk), .rst(rst), .valid_i(in_valid), .data_i({f_y, f_ovf, f_zero}),
      .next_load_i(out_ready), .load_o(load1), .valid_o(out_valid),
      .data_o({out_y, out_ovf, out_zero})
    );
  end else if (LATENCY == 2) begin : g_lat2
    logic v1, load2;
    a2s_pipe_stage #(.W(FW)) u_s1 (
      .clk(clk), .rst(rst), .valid_i(in_valid), .data_i({s_inv, s_inc, in_mode, s_min}),
      .next_load_i(load2), .load_o(load1), .valid_o(v1),
      .data_o({f_inv, f_inc, f_mode, f_min})
    );
    a2s_pipe_stage #(.W(OW)) u_s2 (
      .clk(clk), .rst(rst), .valid_i(v1), .data_i({f_y, f_ovf, f_zero}),
      .next_load_i(out_ready), .load_o(load2), .valid_o(out_valid),
      .data_o({out_y, out_ovf, out_zero})
    );
  end else begin : g_bad
    $error("a2s_pipe: LATENCY must be 1 or 2");
  end
endmodule

// File: tb/tb_a2s_pipe.sv
// tb_a2s_pipe: table vectors plus stream/backpressure/reset sequences, scoreboard checked
module tb_a2s_pipe;
  typedef struct {
    logic [31:0] y;
    logic        ovf;
    logic        zero;
    int          acc;
  } exp_t;
  typedef struct {
    logic [1:0]  m;
    logic [31:0] a;
    logic [31:0] y;
    logic        ovf;
    logic        zero;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv[2], ir[2], ov[2], ordy[2], ovf[2], oz[2];
  logic [31:0] ia[2], oy[2];
  logic [1:0]  im[2];
  exp_t        q0[$], q1[$];
  vec_t        tbl[14];
  int          errs = 0, checks = 0, cyc = 0, nout[2];
  bit          lat_chk = 1'b0;

  a2s_pipe #(.WIDTH(32), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(ia[0]), .in_mode(im[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_y(oy[0]), .out_ovf(ovf[0]), .out_zero(oz[0])
  );
  a2s_pipe #(.WIDTH(32), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(ia[1]), .in_mode(im[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_y(oy[1]), .out_ovf(ovf[1]), .out_zero(oz[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] want);
    checks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  function automatic exp_t mk(logic [31:0] y, logic o, logic z);
    exp_t e;
    e.y = y; e.ovf = o; e.zero = z; e.acc = 0;
    return e;
  endfunction

  function automatic exp_t model(logic [1:0] m, logic [31:0] a);
    exp_t e;
    logic [31:0] t, mn;
    mn = 32'h8000_0000;
    t = 32'd0 - a;
    e.ovf = 1'b0;
    case (m)
      2'd0: begin e.y = t; e.ovf = (a == mn); end
      2'd1: begin e.y = $signed(a) < 0 ? t : a; e.ovf = (a == mn); end
      2'd2: e.y = a[31] ? 32'd0 - {1'b0, a[30:0]} : a;
      default: begin
        if (a == mn) begin e.y = 32'hFFFF_FFFF; e.ovf = 1'b1; end
        else e.y = a[31] ? {1'b1, t[30:0]} : a;
      end
    endcase
    e.zero = (e.y == 32'd0);
    e.acc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (ov[d] && ordy[d]) begin
          exp_t e;
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            checks++; errs++;
            $display("FAIL unexpected_out dut%0d: got y=%h want none", d, oy[d]);
          end else begin
            if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
            chk($sformatf("result dut%0d", d), 64'({oy[d], ovf[d], oz[d]}),
                64'({e.y, e.ovf, e.zero}));
            if (lat_chk) chk($sformatf("latency dut%0d", d), 64'(cyc - e.acc), 64'(d == 0 ? 2 : 1));
          end
          nout[d]++;
        end
      end
    end
  end

  task automatic send(int d, logic [1:0] m, logic [31:0] a, exp_t e);
    bit ok = 1'b0;
    iv[d] = 1'b1; im[d] = m; ia[d] = a;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = ir[d];
    end
    if (!ok) begin
      checks++; errs++;
      $display("FAIL accept_timeout dut%0d: got in_ready=0 want 1", d);
    end else begin
      e.acc = cyc;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk); #1;
    iv[d] = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && (q0.size() + q1.size()) > 0; t++) begin
      @(negedge clk); #1;
    end
    chk("drain", 64'(q0.size() + q1.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n0, c0;
    logic [31:0] y0, a;
    logic [1:0] m;
    bit stable;
    tbl[0]  = '{2'd0, 32'hF0F0F0F0, 32'h0F0F0F10, 1'b0, 1'b0};
    tbl[1]  = '{2'd1, 32'hFFFFFFFB, 32'h00000005, 1'b0, 1'b0};
    tbl[2]  = '{2'd0, 32'h80000000, 32'h80000000, 1'b1, 1'b0};
    tbl[3]  = '{2'd1, 32'h00000000, 32'h00000000, 1'b0, 1'b1};
    tbl[4]  = '{2'd2, 32'h80000005, 32'hFFFFFFFB, 1'b0, 1'b0};
    tbl[5]  = '{2'd3, 32'hFFFFFFFB, 32'h80000005, 1'b0, 1'b0};
    tbl[6]  = '{2'd2, 32'h80000000, 32'h00000000, 1'b0, 1'b1};
    tbl[7]  = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0};
    tbl[8]  = '{2'd1, 32'h80000000, 32'h80000000, 1'b1, 1'b0};
    tbl[9]  = '{2'd3, 32'h00000007, 32'h00000007, 1'b0, 1'b0};
    tbl[10] = '{2'd2, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0};
    tbl[11] = '{2'd0, 32'h00000000, 32'h00000000, 1'b0, 1'b1};
    tbl[12] = '{2'd0, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0};
    tbl[13] = '{2'd2, 32'hFFFFFFFF, 32'h80000001, 1'b0, 1'b0};
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; ia[d] = '0; im[d] = '0; ordy[d] = 1'b1; nout[d] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("in_ready_during_rst", 64'(ir[0]), 64'd0);
    chk("reset_outputs", 64'({ov[0], oy[0], ovf[0], oz[0]}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(ir[0]), 64'd1);
    @(posedge clk); #1;
    // Directed vectors, one at a time, each with exact-latency check
    lat_chk = 1'b1;
    for (int i = 0; i < 14; i++) begin
      send(0, tbl[i].m, tbl[i].a, mk(tbl[i].y, tbl[i].ovf, tbl[i].zero));
      drain();
    end
    // Back-to-back streams with alternating modes on both latencies
    for (int d = 0; d < 2; d++) begin
      n0 = nout[d];
      c0 = cyc;
      for (int i = 0; i < 8; i++) begin
        m = 2'(i % 4);
        a = (i == 3) ? 32'h80000000 : $urandom;
        send(d, m, a, model(m, a));
      end
      chk($sformatf("stream_rate dut%0d", d), 64'(cyc - c0), 64'd8);
      drain();
      chk($sformatf("stream_count dut%0d", d), 64'(nout[d] - n0), 64'd8);
    end
    // Backpressure mid-stream
    lat_chk = 1'b0;
    n0 = nout[0];
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          m = 2'($urandom_range(0, 3));
          a = $urandom;
          send(0, m, a, model(m, a));
        end
      end
      begin
        for (int t = 0; t < 50 && nout[0] < n0 + 2; t++) @(negedge clk);
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        @(negedge clk);
        y0 = oy[0];
        stable = ov[0];
        repeat (4) begin
          @(negedge clk);
          if (oy[0] !== y0 || !ov[0]) stable = 1'b0;
        end
        chk("stall_in_ready", 64'(ir[0]), 64'd0);
        chk("stall_out_stable", 64'(stable), 64'd1);
        @(posedge clk); #1;
        ordy[0] = 1'b1;
      end
    join
    drain();
    chk("bp_count", 64'(nout[0] - n0), 64'd10);
    // Reset with two beats in flight
    lat_chk = 1'b1;
    send(0, 2'd0, 32'h00001234, model(2'd0, 32'h00001234));
    send(0, 2'd1, 32'hFFFF0000, model(2'd1, 32'hFFFF0000));
    rst = 1'b1;
    @(negedge clk);
    chk("in_ready_mid_rst", 64'(ir[0]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete();
    chk("flushed_outputs", 64'({ov[0], oy[0], ovf[0], oz[0]}), 64'd0);
    send(0, 2'd3, 32'hFFFFFFF0, model(2'd3, 32'hFFFFFFF0));
    drain();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
